keypad_matrix_scanner: RTL and testbench
========================================

# keypad_matrix_scanner

- Scans a 4x4 DTMF telephone keypad and debounces it.
- Drives one column low at a time and samples the four pulled-up rows.
- Rejects multi-key (ghost) patterns and debounces press and release over whole scans.
- Presents a 5-bit `{valid, code[3:0]}` word that feeds the NIOS keyboard PIO input port directly.

## Interface

- `SCAN_DIV`, 12000: clock cycles each column is driven (1 ms at 12 MHz); minimum 4.
- `DEBOUNCE_SCANS`, 4: consecutive identical full scans required to accept a press or a release; minimum 1.
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `row_in` input 4: keypad rows, active-low, external pull-ups, asynchronous to `clk`.
- `col_out` output 4: column drive, active-low one-hot.
- `key_out` output 5: bit 4 = key held (debounced); bits 3:0 = key code.
- `key_event` output 1: one-cycle pulse when a new press is accepted.

## Operation

- **Row synchronizer:** 2-flop synchronizer on `row_in`, reset to 4'hF.
- **Column sequencer:**
  - Dwell counter runs 0..`SCAN_DIV`-1; column index runs 0..3 and wraps 3->0.
  - `col_out` = ~(1 << col).
  - On dwell count `SCAN_DIV`-1, synchronized rows are sampled into a per-scan accumulator for the current column. The column then advances.
- **Scan result:** after column 3 is sampled, `scan_done` is asserted for one cycle.
  - Exactly one low row/column crossing in the scan: result = HIT, code = {row[1:0], col[1:0]} (row 2, col 1 gives 4'h9).
  - Zero crossings, or two or more: result = NONE (ghost rejection).
  - The accumulator clears for the next scan.
- **Debounce FSM** (evaluated only on `scan_done`; `cnt` counts matching scans):
  - IDLE:
    - HIT -> PRESS_DEB, cand = code, cnt = 1.
    - If `DEBOUNCE_SCANS` == 1, go straight to HELD with accept actions instead.
  - PRESS_DEB:
    - HIT with the same code: cnt+1. On reaching `DEBOUNCE_SCANS` -> HELD and accept.
    - HIT with a different code: cand = code, cnt = 1.
    - NONE -> IDLE.
  - HELD:
    - HIT (any code) -> stay; a second key never replaces the held one.
    - NONE -> RELEASE_DEB, cnt = 1. If `DEBOUNCE_SCANS` == 1, release immediately.
  - RELEASE_DEB:
    - NONE: cnt+1. On reaching `DEBOUNCE_SCANS` -> IDLE and release.
    - HIT (any code) -> HELD.
  - Accept actions: `key_out` <= {1, cand}; `key_event` <= 1 for one cycle.
  - Release actions: `key_out[4]` <= 0; `key_out[3:0]` per Configuration.
- All outputs are registered. `cnt` width is clog2(`DEBOUNCE_SCANS`+1) and saturates; it never wraps.

## Timing

- **Reset values:** `col_out` = 4'b1110, `key_out` = 5'h00, `key_event` = 0, FSM = IDLE, counters = 0.
- **Scan period:** 4 x `SCAN_DIV` cycles.
- **Sample point:** the sample at dwell `SCAN_DIV`-1 reflects the pins at dwell `SCAN_DIV`-3 (synchronizer delay). Row settling therefore has `SCAN_DIV`-3 cycles.
- **Press latency:** `key_out`/`key_event` update 1 cycle after the `scan_done` of the `DEBOUNCE_SCANS`-th matching scan.
  - This counts whole scans only; a press that begins mid-scan first yields a partial scan.
- **Release latency:** `DEBOUNCE_SCANS` NONE scans, then +1 cycle.
- **Reset mid-operation:** everything returns to reset values immediately. No `key_event` is produced by reset.
- There is no back-pressure; the consumer polls `key_out`.

## Configuration

- `KEYPAD_LATCH_CODE_EN` defined: on release only `key_out[4]` clears; `key_out[3:0]` keeps the last accepted code until the next accept.
- Not defined: on release `key_out` returns to 5'h00.

## Test plan

All scenarios use `SCAN_DIV`=4, `DEBOUNCE_SCANS`=3 (scan = 16 cycles).

- **Reset/idle:** hold rows 4'hF for 100 cycles -> `col_out` cycles 1110, 1101, 1011, 0111 every 4 cycles; `key_out` = 0; no `key_event`.
- **Clean press:** assert row 2 low while col 1 is driven, from before a scan start, held stable -> `key_out` = 5'h19 and one `key_event` pulse, 1 cycle after the 3rd `scan_done`. Release -> `key_out[4]` = 0 after 3 NONE scans.
- **Bounce:** alternate HIT/NONE scans for key 4'h5 for 5 scans, then stable -> accept occurs only after 3 consecutive HIT scans; exactly one `key_event`.
- **Ghost rejection:** press keys 4'h0 and 4'hF together -> `key_out` stays 0. Press 4'h0 alone, accept, then add 4'hF -> `key_out` stays 5'h10; release both -> cleared.
- **Reset mid-press:** pulse `reset_n` low during PRESS_DEB (cnt = 2) -> outputs at reset values immediately; a re-press needs 3 full scans again.
- **Macro:** with `KEYPAD_LATCH_CODE_EN`, press/release 4'hA -> after release `key_out` = 5'h0A. Without it -> 5'h00.

Source files
------------

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: one-hot active-low column drive, ghost rejection and whole-scan debounce.
// Optional build macro KEYPAD_LATCH_CODE_EN keeps the last accepted code on key_out[3:0] after release.
module keypad_matrix_scanner #(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [4:0] key_out,
    output logic       key_event
);
    // state       | meaning
    // IDLE        | no key held, no candidate
    // PRESS_DEB   | counting identical HIT scans for cand
    // HELD        | key accepted and reported on key_out
    // RELEASE_DEB | counting NONE scans before release

    localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W   = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
    localparam logic [CNT_W-1:0]   CNT_TGT    = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        RELEASE_DEB
    } state_t;

    logic [3:0]         row_meta;
    logic [3:0]         row_sync;
    logic [DWELL_W-1:0] dwell;
    logic [1:0]         col;
    logic               dwell_end;
    logic [15:0]        acc;
    logic [15:0]        acc_nxt;
    logic               scan_done;
    logic               scan_hit;
    logic [3:0]         scan_code;

    state_t             state;
    state_t             state_nxt;
    logic [3:0]         cand;
    logic [3:0]         cand_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [4:0]         key_out_nxt;
    logic               key_event_nxt;
    logic [4:0]         key_released;

    assign dwell_end = (dwell == DWELL_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_meta  <= 4'hF;
            row_sync  <= 4'hF;
            dwell     <= '0;
            col       <= 2'd0;
            col_out   <= 4'b1110;
            acc       <= '0;
            scan_done <= 1'b0;
        end else begin
            row_meta  <= row_in;
            row_sync  <= row_meta;
            acc       <= acc_nxt;
            scan_done <= dwell_end && (col == 2'd3);
            if (dwell_end) begin
                dwell   <= '0;
                col     <= col + 2'd1;
                col_out <= {col_out[2:0], col_out[3]};
            end else begin
                dwell   <= dwell + DWELL_ONE;
            end
        end
    end

    // Accumulator bit {row, col} is set when that crossing read low; cleared while the result is consumed.
    always_comb begin
        acc_nxt = scan_done ? 16'h0000 : acc;
        if (dwell_end) begin
            for (int r = 0; r < 4; r++) begin
                acc_nxt[{r[1:0], col}] = ~row_sync[r];
            end
        end
    end

    always_comb begin
        scan_code = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (acc[i]) begin
                scan_code = 4'(i);
            end
        end
        scan_hit = ($countones(acc) == 1);
    end

`ifdef KEYPAD_LATCH_CODE_EN
    assign key_released = {1'b0, key_out[3:0]};
`else
    assign key_released = 5'h00;
`endif

    assign cnt_inc = (cnt == CNT_TGT) ? cnt : cnt + CNT_ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cand      <= 4'h0;
            cnt       <= '0;
            key_out   <= 5'h00;
            key_event <= 1'b0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            cnt       <= cnt_nxt;
            key_out   <= key_out_nxt;
            key_event <= key_event_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cand_nxt      = cand;
        cnt_nxt       = cnt;
        key_out_nxt   = key_out;
        key_event_nxt = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (scan_hit) begin
                        cand_nxt = scan_code;
                        if (CNT_ONE == CNT_TGT) begin
                            state_nxt     = HELD;
                            cnt_nxt       = '0;
                            key_out_nxt   = {1'b1, scan_code};
                            key_event_nxt = 1'b1;
                        end else begin
                            state_nxt = PRESS_DEB;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                PRESS_DEB: begin
                    if (!scan_hit) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (scan_code != cand) begin
                        cand_nxt = scan_code;
                        cnt_nxt  = CNT_ONE;
                    end else if (cnt_inc == CNT_TGT) begin
                        state_nxt     = HELD;
                        cnt_nxt       = '0;
                        key_out_nxt   = {1'b1, cand};
                        key_event_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                HELD: begin
                    // Any HIT keeps the held key; a second key never takes over.
                    if (!scan_hit) begin
                        if (CNT_ONE == CNT_TGT) begin
                            state_nxt   = IDLE;
                            cnt_nxt     = '0;
                            key_out_nxt = key_released;
                        end else begin
                            state_nxt = RELEASE_DEB;
                            cnt_nxt   = CNT_ONE;
                        end
                    end
                end
                RELEASE_DEB: begin
                    if (scan_hit) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else if (cnt_inc == CNT_TGT) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        key_out_nxt = key_released;
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner: physical keypad model plus a scan-history debounce model.
module tb_keypad_matrix_scanner;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int SCAN_CYC = 4 * SCAN_DIV;
`ifdef KEYPAD_LATCH_CODE_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [4:0] key_out;
    logic       key_event;
    logic [15:0] pressed = 16'h0000;

    int n_cmp = 0;
    int n_fail = 0;
    int n = 0;
    int ev_cnt = 0;
    int ev0;

    bit         held;
    int         run_code;
    int         run_len;
    int         res;
    logic [4:0] exp_key;
    logic [4:0] nxt_key;
    logic       exp_evt;
    logic       nxt_evt;
    logic [3:0] exp_col;

    keypad_matrix_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .row_in(row_in),
        .col_out(col_out),
        .key_out(key_out),
        .key_event(key_event)
    );

    always #5 clk = ~clk;

    // Key index 4*row+col sits at that row/column crossing.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[4*r+c] && !col_out[c]) row_in[r] = 1'b0;
            end
        end
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] key(input int c);
        logic [15:0] one;
        one = 16'h0001;
        return one << c;
    endfunction

    // A scan is a HIT only when exactly one key is down; returns its code, else -1.
    function automatic int scan_result(input logic [15:0] p);
        if ($countones(p) != 1) return -1;
        for (int i = 0; i < 16; i++) if (p[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            n = 0; held = 1'b0; run_code = -2; run_len = 0;
            exp_key = 5'h00; nxt_key = 5'h00; exp_evt = 1'b0; nxt_evt = 1'b0;
            chk("rst_col", 32'(col_out), 32'hE);
            chk("rst_key", 32'(key_out), 32'h0);
            chk("rst_evt", 32'(key_event), 32'h0);
        end else begin
            n = n + 1;
            if (n % SCAN_CYC == 1) begin
                exp_key = nxt_key;
                exp_evt = nxt_evt;
            end else begin
                exp_evt = 1'b0;
            end
            exp_col = 4'b0001 << ((n / SCAN_DIV) % 4);
            exp_col = ~exp_col;
            chk("col_out", 32'(col_out), 32'(exp_col));
            chk("key_out", 32'(key_out), 32'(exp_key));
            chk("key_event", 32'(key_event), 32'(exp_evt));
            if (key_event) ev_cnt++;
            if (n % SCAN_CYC == 0) begin
                res = scan_result(pressed);
                if (res == run_code) run_len++;
                else begin run_code = res; run_len = 1; end
                nxt_evt = 1'b0;
                if (!held && run_code >= 0 && run_len >= DEB) begin
                    held = 1'b1;
                    nxt_key = {1'b1, 4'(run_code)};
                    nxt_evt = 1'b1;
                end else if (held && run_code < 0 && run_len >= DEB) begin
                    held = 1'b0;
                    nxt_key = LATCH ? {1'b0, nxt_key[3:0]} : 5'h00;
                end
            end
        end
    end

    task automatic next_scans(input int k);
        for (int i = 0; i < k; i++) begin
            do begin @(negedge clk); #1; end while (n % SCAN_CYC != 0);
        end
    endtask

    task automatic step;
        @(negedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;

        // idle
        next_scans(7);
        chk("idle_key", 32'(key_out), 32'h0);
        chk("idle_events", 32'(ev_cnt), 32'h0);

        // clean press of 9 (row 2, col 1)
        ev0 = ev_cnt;
        pressed = key(9);
        next_scans(3);
        chk("press_pre", 32'(key_out), 32'h0);
        step;
        chk("press_key", 32'(key_out), 32'h19);
        chk("press_evt", 32'(key_event), 32'h1);
        step;
        chk("press_evt_end", 32'(key_event), 32'h0);
        next_scans(1);
        pressed = 16'h0000;
        next_scans(3);
        chk("release_pre", 32'(key_out), 32'h19);
        step;
        chk("release_key", 32'(key_out), LATCH ? 32'h09 : 32'h00);
        chk("press_events", 32'(ev_cnt - ev0), 32'h1);

        // bounce on key 5
        next_scans(1);
        ev0 = ev_cnt;
        for (int i = 0; i < 5; i++) begin
            pressed = (i % 2 == 0) ? key(5) : 16'h0000;
            next_scans(1);
        end
        pressed = key(5);
        next_scans(1);
        step;
        chk("bounce_early", 32'(key_out), 32'h0);
        next_scans(1);
        step;
        chk("bounce_key", 32'(key_out), 32'h15);
        next_scans(1);
        pressed = 16'h0000;
        next_scans(4);
        chk("bounce_events", 32'(ev_cnt - ev0), 32'h1);

        // ghost rejection
        pressed = key(0) | key(15);
        next_scans(4);
        step;
        chk("ghost_key", 32'(key_out), LATCH ? 32'h05 : 32'h00);
        next_scans(1);
        pressed = key(0);
        next_scans(3);
        step;
        chk("ghost_held", 32'(key_out), 32'h10);
        next_scans(1);
        pressed = key(0) | key(15);
        next_scans(2);
        pressed = key(0);
        step;
        chk("ghost_second", 32'(key_out), 32'h10);
        next_scans(1);
        step;
        chk("ghost_rehold", 32'(key_out), 32'h10);
        next_scans(1);
        pressed = 16'h0000;
        next_scans(3);
        step;
        chk("ghost_clear", 32'(key_out), 32'h00);

        // reset in PRESS_DEB with cnt = 2
        next_scans(1);
        pressed = key(5);
        next_scans(2);
        repeat (5) step;
        chk("mid_pre", 32'(key_out), 32'h0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_key", 32'(key_out), 32'h0);
        chk("mid_rst_col", 32'(col_out), 32'hE);
        chk("mid_rst_evt", 32'(key_event), 32'h0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        next_scans(2);
        step;
        chk("repress_early", 32'(key_out), 32'h0);
        next_scans(1);
        step;
        chk("repress_key", 32'(key_out), 32'h15);
        next_scans(1);
        pressed = 16'h0000;
        next_scans(4);

        // key A release, code kept only when latching
        pressed = key(10);
        next_scans(3);
        step;
        chk("a_key", 32'(key_out), 32'h1A);
        next_scans(1);
        pressed = 16'h0000;
        next_scans(3);
        step;
        chk("a_release", 32'(key_out), LATCH ? 32'h0A : 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
